esteira_line_ctrl: RTL and testbench
====================================

Name: esteira_line_ctrl

Overview:
Parametrised conveyor-line controller for the DE2 production-line design. Operator switches register product codes into a queue. A ticked conveyor shift register moves products along STAGES positions, and the block counts finished products for the two-digit HEX display. It sits between the board I/O top level and the display/LCD logic.

Parameters:
CODE_W, 4, product code width (switch field I)
STAGES, 10, conveyor positions (one LED each)
QDEPTH, 8, entry queue depth (power of 2, >=2)
STEP_DIV, 50_000_000, CLOCK_50 cycles per conveyor step
GAP_MODE_SLOTS, 1, empty slots enforced between products when spaced mode is selected

Ports:
CLOCK_50  in  1  50 MHz system clock
RESET  in  1  asynchronous, active-low reset
code_in  in  CODE_W  product code from switches
reg_sw  in  1  register switch; each rising edge enqueues code_in
prod_en  in  1  1 = conveyor runs, 0 = conveyor halted
mode_sp  in  1  0 = dense loading, 1 = spaced loading
leds  out  STAGES  occupancy of each conveyor position, bit0 = entry
fim  out  1  one-cycle pulse when a product leaves the last stage
last_code  out  CODE_W  code of the most recently finished product
done_bcd  out  8  finished-product count, BCD {tens, units}, 00..99
q_level  out  $clog2(QDEPTH)+1  queue occupancy
q_full  out  1  queue full
q_ovf  out  1  sticky: a registration was dropped because the queue was full

Behaviour:
- Reset (RESET=0, asynchronous) forces all outputs to 0: leds=0, fim=0, last_code=0, done_bcd=8'h00, q_level=0, q_full=0, q_ovf=0. It also clears the queue, the conveyor, the tick counter and the synchronizers. A reset in the middle of operation discards every product in flight.
- Input sync: reg_sw, prod_en and mode_sp each pass through a 2-FF synchronizer.
- Edge detect: reg_sw is edge-detected after synchronization. One rising edge produces one push request. code_in is sampled in the same cycle as the push request.
- Queue: circular FIFO, QDEPTH entries.
  - Push is accepted if the queue is not full, or if a pop occurs in the same cycle.
  - A push that is not accepted sets q_ovf. q_ovf clears only on reset.
  - q_level and q_full update in the cycle after push/pop. Push and pop in the same cycle leave q_level unchanged.
- Tick: a counter runs 0..STEP_DIV-1 while prod_en=1 and asserts tick for one cycle on wrap. When prod_en=0 the counter holds its value; it does not clear.
- Conveyor: arrays valid[STAGES] and code[STAGES]. On tick:
  - Every position shifts up one (i -> i+1).
  - A product in the last stage exits: fim=1 for that cycle, last_code is loaded with its code, done_bcd increments.
  - BCD increment: units 9 -> 0 carries into tens; 99 -> 00 wraps.
- Entry load, on the same tick: stage0 loads the queue head (pop) if the queue is non-empty and one of these holds:
  - mode_sp=0, or
  - mode_sp=1 and positions 1..GAP_MODE_SLOTS are empty after the shift.
  - Otherwise stage0 becomes empty.
- No tick means no movement and no pop. leds = valid, registered.
- Latency: a product pushed into an empty queue enters stage0 on the next tick. It exits STAGES ticks after entry.
- Changing mode_sp mid-run affects only loads after the synchronizer delay. Products already on the conveyor are untouched.

Decomposition:
- Shared package esteira_pkg holds: the CODE_W default, the bcd2_t type (two 4-bit digits), and a function bcd_inc (saturating-free wrap 99->00).
- One natural sub-module: esteira_fifo, a parametrised CODE_W x QDEPTH FIFO with level/full/empty outputs and the same-cycle push/pop rule.
- Tick divider, synchronizers and conveyor stay in the top block.

Test Plan:
- Reset: drive RESET=0 mid-run with 3 products on the conveyor and 2 queued -> all outputs 0 asynchronously. After release, q_level=0 and no fim pulse until new products are registered.
- Dense flow (STEP_DIV=4, STAGES=10, mode_sp=0): register codes 3, 5, 7 back-to-back -> they occupy consecutive LEDs. fim fires on ticks 10, 11, 12 after the first load with last_code 3, 5, 7, and done_bcd ends at 8'h03.
- Spaced flow (mode_sp=1, GAP=1): register codes 1, 2 -> leds show pattern ...101. Products exit 2 ticks apart.
- Queue overflow (prod_en=0, QDEPTH=8): send 9 rising edges -> q_level=8, q_full=1, q_ovf=1. Queue contents are the first 8 codes in order.
- Full with simultaneous pop: with the queue full and prod_en=1, a push arrives on the tick cycle -> push is accepted, q_level stays 8, q_ovf is unchanged.
- BCD wrap: preload 99 finished products (or force the count) and finish one more -> done_bcd goes 8'h99 to 8'h00, with fim a single-cycle pulse.

Source files
------------

// File: rtl/esteira_pkg.sv
// Shared types and helpers for the conveyor-line controller.
package esteira_pkg;

    localparam int CODE_W_DEF = 4;

    typedef struct packed {
        logic [3:0] tens;
        logic [3:0] units;
    } bcd2_t;

    // Two-digit BCD increment; 99 rolls over to 00.
    function automatic bcd2_t bcd_inc(input bcd2_t v);
        bcd2_t r;
        r = v;
        if (v.units == 4'd9) begin
            r.units = 4'd0;
            r.tens  = (v.tens == 4'd9) ? 4'd0 : v.tens + 4'd1;
        end else begin
            r.units = v.units + 4'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/esteira_line_ctrl_if.sv
// Operator/display signal bundle of the conveyor-line controller.
interface esteira_line_ctrl_if #(
    parameter int CODE_W = esteira_pkg::CODE_W_DEF,
    parameter int STAGES = 10,
    parameter int QDEPTH = 8
);
    localparam int LVL_W = $clog2(QDEPTH) + 1;

    logic [CODE_W-1:0] code_in;
    logic              reg_sw;
    logic              prod_en;
    logic              mode_sp;
    logic [STAGES-1:0] leds;
    logic              fim;
    logic [CODE_W-1:0] last_code;
    logic [7:0]        done_bcd;
    logic [LVL_W-1:0]  q_level;
    logic              q_full;
    logic              q_ovf;

    modport master (
        output code_in, reg_sw, prod_en, mode_sp,
        input  leds, fim, last_code, done_bcd, q_level, q_full, q_ovf
    );

    modport slave (
        input  code_in, reg_sw, prod_en, mode_sp,
        output leds, fim, last_code, done_bcd, q_level, q_full, q_ovf
    );
endinterface

// File: rtl/esteira_fifo.sv
// Circular product-code FIFO with first-word-fall-through head and level count.
// A push into a full FIFO is still accepted when a pop happens in the same cycle.
module esteira_fifo #(
    parameter int W     = 4,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic [W-1:0]               data_i,
    output logic [W-1:0]               data_o,
    output logic [$clog2(DEPTH):0]     level_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic                       push_ok_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] count_q, count_d;
    logic          pop_ok;
    logic          push_ok;

    assign empty_o   = (count_q == '0);
    assign full_o    = (count_q == FULL_LVL);
    assign pop_ok    = pop_i && !empty_o;
    assign push_ok   = push_i && (!full_o || pop_ok);
    assign push_ok_o = push_ok;
    assign data_o    = mem_q[rd_ptr_q];
    assign level_o   = count_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (push_ok && !pop_ok) begin
            count_d = count_q + 1'b1;
        end else if (!push_ok && pop_ok) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset; the pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/esteira_line_ctrl.sv
// Conveyor-line controller: switch-registered product queue feeding a ticked
// conveyor shift register, with a two-digit BCD count of finished products.
module esteira_line_ctrl
    import esteira_pkg::*;
#(
    parameter int CODE_W         = CODE_W_DEF,
    parameter int STAGES         = 10,
    parameter int QDEPTH         = 8,
    parameter int STEP_DIV       = 50_000_000,
    parameter int GAP_MODE_SLOTS = 1
) (
    input  logic               CLOCK_50,
    input  logic               RESET,
    esteira_line_ctrl_if.slave bus
);
    localparam int CNT_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STEP_DIV - 1);
    localparam int LVL_W = $clog2(QDEPTH) + 1;

    logic [2:0]        sync1_q, sync2_q;
    logic              reg_prev_q;
    logic              reg_sw_s, prod_en_s, mode_sp_s;
    logic              push_req, push_ok, load, fifo_empty, gap_busy, tick;
    logic [CODE_W-1:0] fifo_head;
    logic [LVL_W-1:0]  fifo_level;
    logic              fifo_full;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [STAGES-1:0] valid_q, valid_d, valid_sh;
    logic [CODE_W-1:0] code_q  [STAGES];
    logic [CODE_W-1:0] code_d  [STAGES];
    logic [CODE_W-1:0] code_sh [STAGES];
    logic              fim_q, fim_d;
    logic [CODE_W-1:0] last_code_q, last_code_d;
    bcd2_t             done_q, done_d;
    logic              ovf_q, ovf_d;

    // Synchronised switch levels, packed as {mode_sp, prod_en, reg_sw}.
    assign reg_sw_s  = sync2_q[0];
    assign prod_en_s = sync2_q[1];
    assign mode_sp_s = sync2_q[2];
    assign push_req  = reg_sw_s & ~reg_prev_q;

    assign tick = prod_en_s && (cnt_q == CNT_LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (prod_en_s) begin
            cnt_d = tick ? '0 : cnt_q + 1'b1;
        end
    end

    // Positions 1..GAP after the shift are stages 0..GAP-1 before it.
    always_comb begin
        gap_busy = 1'b0;
        for (int i = 0; i < STAGES - 1; i++) begin
            if (i < GAP_MODE_SLOTS) begin
                gap_busy = gap_busy | valid_q[i];
            end
        end
    end

    assign load  = tick && !fifo_empty && (!mode_sp_s || !gap_busy);
    assign ovf_d = ovf_q | (push_req & ~push_ok);

    esteira_fifo #(
        .W     (CODE_W),
        .DEPTH (QDEPTH)
    ) u_fifo (
        .clk       (CLOCK_50),
        .rst_n     (RESET),
        .push_i    (push_req),
        .pop_i     (load),
        .data_i    (bus.code_in),
        .data_o    (fifo_head),
        .level_o   (fifo_level),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty),
        .push_ok_o (push_ok)
    );

    assign valid_sh[0] = load;
    assign code_sh[0]  = fifo_head;
    for (genvar gi = 1; gi < STAGES; gi++) begin : g_shift
        assign valid_sh[gi] = valid_q[gi-1];
        assign code_sh[gi]  = code_q[gi-1];
    end

    always_comb begin
        valid_d     = valid_q;
        code_d      = code_q;
        fim_d       = 1'b0;
        last_code_d = last_code_q;
        done_d      = done_q;
        if (tick) begin
            valid_d = valid_sh;
            code_d  = code_sh;
            if (valid_q[STAGES-1]) begin
                fim_d       = 1'b1;
                last_code_d = code_q[STAGES-1];
                done_d      = bcd_inc(done_q);
            end
        end
    end

    always_ff @(posedge CLOCK_50 or negedge RESET) begin
        if (!RESET) begin
            sync1_q     <= '0;
            sync2_q     <= '0;
            reg_prev_q  <= 1'b0;
            cnt_q       <= '0;
            valid_q     <= '0;
            code_q      <= '{default: '0};
            fim_q       <= 1'b0;
            last_code_q <= '0;
            done_q      <= '0;
            ovf_q       <= 1'b0;
        end else begin
            sync1_q     <= {bus.mode_sp, bus.prod_en, bus.reg_sw};
            sync2_q     <= sync1_q;
            reg_prev_q  <= reg_sw_s;
            cnt_q       <= cnt_d;
            valid_q     <= valid_d;
            code_q      <= code_d;
            fim_q       <= fim_d;
            last_code_q <= last_code_d;
            done_q      <= done_d;
            ovf_q       <= ovf_d;
        end
    end

    assign bus.leds      = valid_q;
    assign bus.fim       = fim_q;
    assign bus.last_code = last_code_q;
    assign bus.done_bcd  = done_q;
    assign bus.q_level   = fifo_level;
    assign bus.q_full    = fifo_full;
    assign bus.q_ovf     = ovf_q;

endmodule

// File: tb/tb_esteira_line_ctrl.sv
// Directed bench for the conveyor-line controller, STEP_DIV shortened to 4.
module tb_esteira_line_ctrl;
    localparam int CODE_W   = 4;
    localparam int STAGES   = 10;
    localparam int QDEPTH   = 8;
    localparam int STEP_DIV = 4;
    localparam int GAP      = 1;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   n_checks  = 0;
    int   n_fail    = 0;
    int   fim_total = 0;

    esteira_line_ctrl_if #(.CODE_W(CODE_W), .STAGES(STAGES), .QDEPTH(QDEPTH)) bus ();

    esteira_line_ctrl #(
        .CODE_W(CODE_W), .STAGES(STAGES), .QDEPTH(QDEPTH),
        .STEP_DIV(STEP_DIV), .GAP_MODE_SLOTS(GAP)
    ) dut (
        .CLOCK_50 (clk),
        .RESET    (rst_n),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.fim === 1'b1) fim_total <= fim_total + 1;
    end

    task automatic apply_reset();
        bus.reg_sw = 1'b0; bus.prod_en = 1'b0; bus.mode_sp = 1'b0; bus.code_in = '0;
        @(negedge clk); rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic push_code(input logic [3:0] c);
        @(negedge clk);
        bus.code_in = c; bus.reg_sw = 1'b1;
        repeat (4) @(negedge clk);
        bus.reg_sw = 1'b0;
        repeat (4) @(negedge clk);
        $display("push code=%0d level=%0d full=%0b ovf=%0b", c, bus.q_level, bus.q_full, bus.q_ovf);
    endtask

    task automatic test_reset();
        bus.reg_sw = 1'b0; bus.prod_en = 1'b0; bus.mode_sp = 1'b0; bus.code_in = '0;
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if (bus.leds !== 10'h000) begin n_fail++; $display("FAIL reset_leds: got %h expected 000", bus.leds); end
        n_checks++; if (bus.fim !== 1'b0) begin n_fail++; $display("FAIL reset_fim: got %b expected 0", bus.fim); end
        n_checks++; if (bus.done_bcd !== 8'h00) begin n_fail++; $display("FAIL reset_done: got %h expected 00", bus.done_bcd); end
        n_checks++; if ({bus.last_code, bus.q_level, bus.q_full, bus.q_ovf} !== 10'h000) begin
            n_fail++; $display("FAIL reset_queue: got last=%h lvl=%h full=%b ovf=%b expected all 0",
                               bus.last_code, bus.q_level, bus.q_full, bus.q_ovf);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        $display("reset released");
    endtask

    task automatic test_dense();
        logic [3:0] exp_code [3];
        int t0, fims;
        exp_code[0] = 4'd3; exp_code[1] = 4'd5; exp_code[2] = 4'd7;
        t0 = -1; fims = 0;
        bus.mode_sp = 1'b0;
        push_code(4'd3); push_code(4'd5); push_code(4'd7);
        n_checks++; if (bus.q_level !== 4'd3) begin n_fail++; $display("FAIL dense_level: got %0d expected 3", bus.q_level); end
        bus.prod_en = 1'b1;
        for (int c = 0; c < 200 && fims < 3; c++) begin
            @(negedge clk);
            if (t0 < 0 && bus.leds[0] === 1'b1) t0 = c;
            if (t0 >= 0 && c == t0 + 8) begin
                n_checks++; if (bus.leds !== 10'h007) begin n_fail++; $display("FAIL dense_leds: got %h expected 007", bus.leds); end
            end
            if (bus.fim === 1'b1) begin
                $display("dense exit code=%0d at +%0d cycles", bus.last_code, c - t0);
                n_checks++; if (c - t0 != 40 + 4 * fims) begin n_fail++; $display("FAIL dense_time: got %0d expected %0d", c - t0, 40 + 4 * fims); end
                n_checks++; if (bus.last_code !== exp_code[fims]) begin n_fail++; $display("FAIL dense_code: got %0d expected %0d", bus.last_code, exp_code[fims]); end
                fims++;
            end
        end
        n_checks++; if (fims != 3) begin n_fail++; $display("FAIL dense_exits: got %0d expected 3", fims); end
        @(negedge clk);
        n_checks++; if (bus.fim !== 1'b0) begin n_fail++; $display("FAIL dense_fim_pulse: got %b expected 0", bus.fim); end
        n_checks++; if (bus.done_bcd !== 8'h03) begin n_fail++; $display("FAIL dense_done: got %h expected 03", bus.done_bcd); end
        n_checks++; if (bus.leds !== 10'h000) begin n_fail++; $display("FAIL dense_empty: got %h expected 000", bus.leds); end
    endtask

    task automatic test_reset_midrun();
        int found, fims, busy;
        found = 0; fims = 0; busy = 0;
        bus.prod_en = 1'b0;
        push_code(4'd1); push_code(4'd2); push_code(4'd3); push_code(4'd4); push_code(4'd5);
        bus.prod_en = 1'b1;
        for (int c = 0; c < 100 && found == 0; c++) begin
            @(negedge clk);
            if (bus.leds === 10'h007) found = 1;
        end
        n_checks++; if (found == 0) begin n_fail++; $display("FAIL midrun_fill: got leds=%h expected 007", bus.leds); end
        n_checks++; if (bus.q_level !== 4'd2) begin n_fail++; $display("FAIL midrun_level: got %0d expected 2", bus.q_level); end
        #1 rst_n = 1'b0;
        #1;
        n_checks++; if (bus.leds !== 10'h000) begin n_fail++; $display("FAIL midrun_leds: got %h expected 000", bus.leds); end
        n_checks++; if (bus.done_bcd !== 8'h00) begin n_fail++; $display("FAIL midrun_done: got %h expected 00", bus.done_bcd); end
        n_checks++; if ({bus.last_code, bus.q_level, bus.q_full, bus.fim} !== 10'h000) begin
            n_fail++; $display("FAIL midrun_async: got last=%h lvl=%h full=%b fim=%b expected all 0",
                               bus.last_code, bus.q_level, bus.q_full, bus.fim);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (bus.fim === 1'b1) fims++;
            if (bus.leds !== 10'h000) busy++;
        end
        $display("midrun reset: %0d fim pulses, %0d busy samples after release", fims, busy);
        n_checks++; if (fims + busy != 0) begin n_fail++; $display("FAIL midrun_quiet: got fims=%0d busy=%0d expected 0", fims, busy); end
        n_checks++; if (bus.q_level !== 4'd0) begin n_fail++; $display("FAIL midrun_qlevel: got %0d expected 0", bus.q_level); end
    endtask

    task automatic test_spaced();
        int t0, fims, t_first;
        t0 = -1; fims = 0; t_first = 0;
        bus.prod_en = 1'b0; bus.mode_sp = 1'b1;
        push_code(4'd1); push_code(4'd2);
        bus.prod_en = 1'b1;
        for (int c = 0; c < 200 && fims < 2; c++) begin
            @(negedge clk);
            if (t0 < 0 && bus.leds[0] === 1'b1) t0 = c;
            if (t0 >= 0 && c == t0 + 4) begin
                n_checks++; if (bus.leds !== 10'h002) begin n_fail++; $display("FAIL spaced_gap: got %h expected 002", bus.leds); end
            end
            if (t0 >= 0 && c == t0 + 8) begin
                n_checks++; if (bus.leds !== 10'h005) begin n_fail++; $display("FAIL spaced_leds: got %h expected 005", bus.leds); end
            end
            if (bus.fim === 1'b1) begin
                $display("spaced exit code=%0d at +%0d cycles", bus.last_code, c - t0);
                n_checks++; if (bus.last_code !== 4'(fims + 1)) begin n_fail++; $display("FAIL spaced_code: got %0d expected %0d", bus.last_code, fims + 1); end
                if (fims == 0) t_first = c;
                else begin
                    n_checks++; if (c - t_first != 2 * STEP_DIV) begin n_fail++; $display("FAIL spaced_gap_time: got %0d expected %0d", c - t_first, 2 * STEP_DIV); end
                end
                fims++;
            end
        end
        n_checks++; if (fims != 2) begin n_fail++; $display("FAIL spaced_exits: got %0d expected 2", fims); end
        n_checks++; if (bus.done_bcd !== 8'h02) begin n_fail++; $display("FAIL spaced_done: got %h expected 02", bus.done_bcd); end
    endtask

    task automatic test_overflow();
        int fims;
        fims = 0;
        apply_reset();
        for (int i = 1; i <= 9; i++) push_code(4'(i));
        n_checks++; if (bus.q_level !== 4'd8) begin n_fail++; $display("FAIL ovf_level: got %0d expected 8", bus.q_level); end
        n_checks++; if (bus.q_full !== 1'b1) begin n_fail++; $display("FAIL ovf_full: got %b expected 1", bus.q_full); end
        n_checks++; if (bus.q_ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_flag: got %b expected 1", bus.q_ovf); end
        bus.prod_en = 1'b1;
        for (int c = 0; c < 150; c++) begin
            @(negedge clk);
            if (bus.fim === 1'b1) begin
                $display("ovf drain exit code=%0d", bus.last_code);
                n_checks++; if (bus.last_code !== 4'(fims + 1)) begin n_fail++; $display("FAIL ovf_order: got %0d expected %0d", bus.last_code, fims + 1); end
                fims++;
            end
        end
        n_checks++; if (fims != 8) begin n_fail++; $display("FAIL ovf_exits: got %0d expected 8", fims); end
        n_checks++; if ({bus.q_ovf, bus.q_full} !== 2'b10) begin n_fail++; $display("FAIL ovf_sticky: got ovf=%b full=%b expected ovf=1 full=0", bus.q_ovf, bus.q_full); end
    endtask

    task automatic test_full_pop();
        int fims;
        fims = 0;
        apply_reset();
        for (int i = 1; i <= 8; i++) push_code(4'(i));
        n_checks++; if ({bus.q_full, bus.q_ovf} !== 2'b10) begin n_fail++; $display("FAIL fp_setup: got full=%b ovf=%b expected full=1 ovf=0", bus.q_full, bus.q_ovf); end
        // Counter is at 0, so the first tick lands 6 edges after prod_en is driven.
        @(negedge clk); bus.prod_en = 1'b1;
        repeat (3) @(negedge clk);
        bus.code_in = 4'd9; bus.reg_sw = 1'b1;
        @(negedge clk); bus.reg_sw = 1'b0;
        @(negedge clk);
        n_checks++; if ({bus.leds, bus.q_level} !== {10'h000, 4'd8}) begin n_fail++; $display("FAIL fp_pre_tick: got leds=%h lvl=%0d expected leds=000 lvl=8", bus.leds, bus.q_level); end
        @(negedge clk);
        $display("tick with push: leds=%h level=%0d ovf=%b", bus.leds, bus.q_level, bus.q_ovf);
        n_checks++; if (bus.leds !== 10'h001) begin n_fail++; $display("FAIL fp_tick: got leds=%h expected 001", bus.leds); end
        n_checks++; if ({bus.q_level, bus.q_full} !== {4'd8, 1'b1}) begin n_fail++; $display("FAIL fp_level: got lvl=%0d full=%b expected lvl=8 full=1", bus.q_level, bus.q_full); end
        n_checks++; if (bus.q_ovf !== 1'b0) begin n_fail++; $display("FAIL fp_ovf: got %b expected 0", bus.q_ovf); end
        for (int c = 0; c < 150; c++) begin
            @(negedge clk);
            if (bus.fim === 1'b1) begin
                n_checks++; if (bus.last_code !== 4'(fims + 1)) begin n_fail++; $display("FAIL fp_order: got %0d expected %0d", bus.last_code, fims + 1); end
                fims++;
            end
        end
        n_checks++; if (fims != 9) begin n_fail++; $display("FAIL fp_exits: got %0d expected 9", fims); end
    endtask

    task automatic test_bcd_wrap();
        int base, found;
        apply_reset();
        bus.prod_en = 1'b1;
        base = fim_total;
        for (int i = 0; i < 10; i++) push_code(4'(i));
        for (int c = 0; c < 200 && fim_total - base < 10; c++) @(negedge clk);
        @(negedge clk);
        n_checks++; if (bus.done_bcd !== 8'h10) begin n_fail++; $display("FAIL bcd_carry: got %h expected 10", bus.done_bcd); end
        for (int i = 0; i < 89; i++) push_code(4'(i % 16));
        for (int c = 0; c < 200 && fim_total - base < 99; c++) @(negedge clk);
        @(negedge clk);
        $display("after 99 products: done=%h level=%0d", bus.done_bcd, bus.q_level);
        n_checks++; if (bus.done_bcd !== 8'h99) begin n_fail++; $display("FAIL bcd_99: got %h expected 99", bus.done_bcd); end
        push_code(4'hA);
        found = 0;
        for (int c = 0; c < 100 && found == 0; c++) begin
            @(negedge clk);
            if (bus.fim === 1'b1) found = 1;
        end
        n_checks++; if (found == 0) begin n_fail++; $display("FAIL bcd_fim: got no exit expected one"); end
        n_checks++; if ({bus.done_bcd, bus.last_code} !== {8'h00, 4'hA}) begin n_fail++; $display("FAIL bcd_wrap: got done=%h last=%h expected done=00 last=a", bus.done_bcd, bus.last_code); end
        @(negedge clk);
        n_checks++; if ({bus.fim, bus.done_bcd} !== {1'b0, 8'h00}) begin n_fail++; $display("FAIL bcd_pulse: got fim=%b done=%h expected fim=0 done=00", bus.fim, bus.done_bcd); end
    endtask

    initial begin
        test_reset();
        test_dense();
        test_reset_midrun();
        test_spaced();
        test_overflow();
        test_full_pop();
        test_bcd_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
